// File: rtl/reg_bus_hub.sv
// reg_bus_hub: registered transaction engine between the frame address
// decoder (master) and NUM_SLAVES register-file slaves.
//
// A master request is latched and broadcast to all slaves. The hub then waits
// for s_ack, reports completion or fault back to the master, and waits for the
// master to drop m_valid before it accepts another request.
//
// Ports
//   clk, rst           system clock, synchronous active-high reset
//   m_valid            master request (level, held until m_ack/m_fault)
//   m_address, m_data  request address / write data
//   m_ack              1-cycle pulse, transaction completed by a slave
//   m_fault            1-cycle pulse, timeout or multiple responders
//   m_rdata            read-back data, held until the next capture
//   m_rdata_valid      1-cycle pulse with m_ack when a slave returned data
//   s_valid            request broadcast to all slaves
//   s_address, s_data  latched request
//   s_ack              per-slave ack
//   s_data_out         per-slave read data, slave i at [i*DATA_W +: DATA_W]
//   s_data_out_valid   per-slave read-data qualifier
//   busy               high in any state except IDLE
//   err_code           sticky error: [0] timeout, [1] multiple ack
//   txn_count          count of m_ack transactions, wraps

// Per-slave lane: a slice only contributes read data when that slave both
// acks and qualifies its data.
module reg_bus_hub_lane #(
  parameter int DATA_W = 4
) (
  input  logic              ack,
  input  logic              dv,
  input  logic [DATA_W-1:0] data,
  output logic              hit,
  output logic [DATA_W-1:0] data_m
);
  assign hit    = ack & dv;
  assign data_m = hit ? data : '0;
endmodule

module reg_bus_hub #(
  parameter int NUM_SLAVES = 5,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int TIMEOUT    = 15,
  parameter int CNT_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_valid,
  input  logic [ADDR_W-1:0]            m_address,
  input  logic [DATA_W-1:0]            m_data,
  output logic                         m_ack,
  output logic                         m_fault,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_rdata_valid,
  output logic                         s_valid,
  output logic [ADDR_W-1:0]            s_address,
  output logic [DATA_W-1:0]            s_data,
  input  logic [NUM_SLAVES-1:0]        s_ack,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_data_out,
  input  logic [NUM_SLAVES-1:0]        s_data_out_valid,
  output logic                         busy,
  output logic [1:0]                   err_code,
  output logic [CNT_W-1:0]             txn_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  localparam logic [7:0]            TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [NUM_SLAVES-1:0] ONE_S    = NUM_SLAVES'(1);

  state_t     state;
  req_t       req_q;
  logic [7:0] tmo_cnt;

  logic [NUM_SLAVES-1:0]             lane_hit;
  logic [NUM_SLAVES-1:0][DATA_W-1:0] lane_data;
  logic [DATA_W-1:0]                 rd_or;
  logic                              any_ack;
  logic                              multi_ack;

  genvar g;
  generate
    for (g = 0; g < NUM_SLAVES; g++) begin : g_lane
      reg_bus_hub_lane #(.DATA_W(DATA_W)) u_lane (
        .ack    (s_ack[g]),
        .dv     (s_data_out_valid[g]),
        .data   (s_data_out[g*DATA_W +: DATA_W]),
        .hit    (lane_hit[g]),
        .data_m (lane_data[g])
      );
    end
  endgenerate

  // Single ack selects one slice; multiple acks OR the qualified slices.
  always_comb begin
    rd_or = '0;
    for (int i = 0; i < NUM_SLAVES; i++) rd_or |= lane_data[i];
  end

  assign any_ack   = |s_ack;
  // x & (x-1) clears the lowest set bit; anything left means 2+ responders.
  assign multi_ack = |(s_ack & (s_ack - ONE_S));

  assign s_address = req_q.addr;
  assign s_data    = req_q.data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      req_q         <= '0;
      tmo_cnt       <= '0;
      s_valid       <= 1'b0;
      m_ack         <= 1'b0;
      m_fault       <= 1'b0;
      m_rdata       <= '0;
      m_rdata_valid <= 1'b0;
      busy          <= 1'b0;
      err_code      <= 2'b00;
      txn_count     <= '0;
    end else begin
      m_ack         <= 1'b0;
      m_fault       <= 1'b0;
      m_rdata_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (m_valid) begin
            req_q   <= '{addr: m_address, data: m_data};
            s_valid <= 1'b1;
            tmo_cnt <= '0;
            busy    <= 1'b1;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Any ack is checked before the timeout, so an ack on the last
          // allowed cycle completes the transaction normally.
          if (any_ack) begin
            m_ack     <= 1'b1;
            txn_count <= txn_count + CNT_W'(1);
            s_valid   <= 1'b0;
            state     <= S_DONE;
            if (|lane_hit) begin
              m_rdata       <= rd_or;
              m_rdata_valid <= 1'b1;
            end
            if (multi_ack) begin
              m_fault     <= 1'b1;
              err_code[1] <= 1'b1;
            end else begin
              err_code    <= 2'b00;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            m_fault     <= 1'b1;
            err_code[0] <= 1'b1;
            s_valid     <= 1'b0;
            state       <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_DONE: begin
          // Hold here until the master lets go, so a level m_valid that is
          // still high after completion cannot launch a second request.
          if (!m_valid) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          s_valid <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_hub.sv
module tb_reg_bus_hub;
  localparam int NS  = 5;
  localparam int AW  = 4;
  localparam int DW  = 4;
  localparam int TMO = 15;
  localparam int CW  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             m_valid;
  logic [AW-1:0]    m_address;
  logic [DW-1:0]    m_data;
  logic             m_ack, m_fault, m_rdata_valid;
  logic [DW-1:0]    m_rdata;
  logic             s_valid;
  logic [AW-1:0]    s_address;
  logic [DW-1:0]    s_data;
  logic [NS-1:0]    s_ack;
  logic [NS*DW-1:0] s_data_out;
  logic [NS-1:0]    s_data_out_valid;
  logic             busy;
  logic [1:0]       err_code;
  logic [CW-1:0]    txn_count;

  reg_bus_hub #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_address(m_address), .m_data(m_data),
    .m_ack(m_ack), .m_fault(m_fault), .m_rdata(m_rdata), .m_rdata_valid(m_rdata_valid),
    .s_valid(s_valid), .s_address(s_address), .s_data(s_data), .s_ack(s_ack),
    .s_data_out(s_data_out), .s_data_out_valid(s_data_out_valid), .busy(busy),
    .err_code(err_code), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic [1:0]    md_err;
  logic [CW-1:0] md_cnt;
  logic [DW-1:0] md_rd;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [DW-1:0]    data;
    logic [NS-1:0]    mask;
    logic [NS-1:0]    dv;
    logic [NS*DW-1:0] sdo;
    int               delay;  // ack-free s_valid cycles before the ack
    int               hold;   // extra cycles m_valid stays high after completion
    logic             e_ack;
    logic             e_fault;
    logic             e_rdv;
    logic [DW-1:0]    e_rdata;
    logic [1:0]       e_err;
    int               e_w;    // s_valid cycles seen
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d,
      input logic [NS-1:0] mask, input logic [NS-1:0] dv, input logic [NS*DW-1:0] sdo,
      input int delay, input int hold, input logic ea, input logic ef, input logic erv,
      input logic [DW-1:0] erd, input logic [1:0] ee, input int ew);
    vec_t v;
    v.addr = a; v.data = d; v.mask = mask; v.dv = dv; v.sdo = sdo;
    v.delay = delay; v.hold = hold;
    v.e_ack = ea; v.e_fault = ef; v.e_rdv = erv; v.e_rdata = erd; v.e_err = ee; v.e_w = ew;
    return v;
  endfunction

  // Expected result from the behavioural rules: who answered, when, and what
  // the sticky/held state becomes.
  function automatic vec_t predict(input vec_t v);
    vec_t r;
    int nb;
    logic [NS-1:0] hit;
    logic [DW-1:0] acc;
    r = v;
    nb = $countones(v.mask);
    if (nb > 0 && v.delay < TMO) begin
      hit = v.mask & v.dv;
      acc = '0;
      for (int i = 0; i < NS; i++)
        if (hit[i]) acc = acc | DW'(v.sdo >> (i*DW));
      r.e_ack   = 1'b1;
      r.e_fault = (nb > 1);
      r.e_rdv   = (hit != 0);
      r.e_rdata = (hit != 0) ? acc : md_rd;
      r.e_err   = (nb > 1) ? (md_err | 2'b10) : 2'b00;
      r.e_w     = v.delay + 1;
    end else begin
      r.e_ack   = 1'b0;
      r.e_fault = 1'b1;
      r.e_rdv   = 1'b0;
      r.e_rdata = md_rd;
      r.e_err   = md_err | 2'b01;
      r.e_w     = TMO;
    end
    return r;
  endfunction

  task automatic run_txn(input vec_t v);
    int  w;
    bit  done;
    w = 0;
    done = 0;
    m_address = v.addr;
    m_data = v.data;
    m_valid = 1'b1;
    s_data_out = v.sdo;
    s_data_out_valid = v.dv;
    s_ack = '0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (m_ack || m_fault) begin
        done = 1;
      end else if (s_valid) begin
        w++;
        chk("s_address", s_address, v.addr);
        chk("s_data", s_data, v.data);
        chk("busy_wait", busy, 1'b1);
        // master inputs wander while the request is in flight
        m_address = AW'($urandom);
        m_data = DW'($urandom);
        s_ack = (w == v.delay + 1) ? v.mask : '0;
      end
    end
    s_ack = '0;
    if (!done) chk("completion_bound", 0, 1);
    if (v.e_ack) md_cnt = md_cnt + 1'b1;
    md_rd = v.e_rdata;
    md_err = v.e_err;
    chk("m_ack", m_ack, v.e_ack);
    chk("m_fault", m_fault, v.e_fault);
    chk("m_rdata_valid", m_rdata_valid, v.e_rdv);
    chk("m_rdata", m_rdata, md_rd);
    chk("err_code", err_code, md_err);
    chk("txn_count", txn_count, md_cnt);
    chk("wait_cycles", w, v.e_w);
    chk("s_valid_done", s_valid, 1'b0);
    chk("busy_done", busy, 1'b1);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk("hold_m_ack", m_ack, 1'b0);
      chk("hold_m_fault", m_fault, 1'b0);
      chk("hold_s_valid", s_valid, 1'b0);
      chk("hold_busy", busy, 1'b1);
    end
    m_valid = 1'b0;
    @(negedge clk);
    chk("busy_idle", busy, 1'b0);
    chk("m_ack_idle", m_ack, 1'b0);
    chk("m_rdata_held", m_rdata, md_rd);
    chk("txn_count_idle", txn_count, md_cnt);
  endtask

  vec_t tbl[9];

  initial begin
    vec_t v;
    int r;
    tbl[0] = mk(4'h3, 4'hA, 5'b00100, 5'b00000, 20'h00000, 3, 0, 1, 0, 0, 4'h0, 2'b00, 4);
    tbl[1] = mk(4'h5, 4'h0, 5'b10000, 5'b10000, 20'h60000, 0, 0, 1, 0, 1, 4'h6, 2'b00, 1);
    tbl[2] = mk(4'h7, 4'h1, 5'b00000, 5'b00000, 20'h00000, 0, 0, 0, 1, 0, 4'h6, 2'b01, 15);
    tbl[3] = mk(4'h1, 4'h2, 5'b00011, 5'b00011, 20'h00041, 1, 0, 1, 1, 1, 4'h5, 2'b11, 2);
    tbl[4] = mk(4'h2, 4'h3, 5'b00001, 5'b00000, 20'h00000, 0, 3, 1, 0, 0, 4'h5, 2'b00, 1);
    tbl[5] = mk(4'h8, 4'h4, 5'b01000, 5'b01000, 20'h09000, 14, 0, 1, 0, 1, 4'h9, 2'b00, 15);
    tbl[6] = mk(4'h9, 4'h5, 5'b01000, 5'b01000, 20'h09000, 15, 0, 0, 1, 0, 4'h9, 2'b01, 15);
    tbl[7] = mk(4'hB, 4'h6, 5'b10100, 5'b00000, 20'h00000, 2, 1, 1, 1, 0, 4'h9, 2'b11, 3);
    tbl[8] = mk(4'hC, 4'h7, 5'b00010, 5'b00110, 20'h00FC0, 0, 0, 1, 0, 1, 4'hC, 2'b00, 1);

    rst = 1'b1;
    m_valid = 1'b0; m_address = '0; m_data = '0;
    s_ack = '0; s_data_out = '0; s_data_out_valid = '0;
    md_err = 2'b00; md_cnt = '0; md_rd = '0;
    repeat (2) @(negedge clk);
    chk("rst_m_ack", m_ack, 0);
    chk("rst_m_fault", m_fault, 0);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_code, 0);
    chk("rst_cnt", txn_count, 0);
    chk("rst_rdata", m_rdata, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_txn(tbl[i]);

    // reset in the middle of WAIT
    m_address = 4'hE; m_data = 4'h1; m_valid = 1'b1;
    s_data_out = 20'h77777; s_data_out_valid = 5'b00100;
    @(negedge clk);
    chk("pre_rst_s_valid", s_valid, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    m_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_s_valid", s_valid, 0);
    chk("mid_rst_s_address", s_address, 0);
    chk("mid_rst_s_data", s_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err_code, 0);
    chk("mid_rst_cnt", txn_count, 0);
    chk("mid_rst_rdata", m_rdata, 0);
    chk("mid_rst_ack", m_ack, 0);
    chk("mid_rst_fault", m_fault, 0);
    rst = 1'b0;
    md_err = 2'b00; md_cnt = '0; md_rd = '0;
    s_ack = 5'b00100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_ack_m_ack", m_ack, 0);
      chk("late_ack_busy", busy, 0);
      chk("late_ack_rdv", m_rdata_valid, 0);
    end
    s_ack = '0;

    // randomized traffic against the model; enough completions to wrap txn_count
    for (int n = 0; n < 330; n++) begin
      v.addr = AW'($urandom);
      v.data = DW'($urandom);
      v.sdo  = (NS*DW)'($urandom);
      v.dv   = NS'($urandom);
      r = $urandom_range(0, 19);
      if (r == 0) v.mask = '0;
      else if (r < 4) v.mask = NS'($urandom);
      else v.mask = NS'(1) << $urandom_range(0, NS-1);
      v.delay = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 4);
      v.hold  = $urandom_range(0, 2);
      v = predict(v);
      run_txn(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_bus_hub.md
Name: reg_bus_hub

Overview:
- Parametrised register-bus hub between the frame address decoder (master) and NUM_SLAVES register-file slaves.
- Slaves include the clock handler, UART, channel, colour and resolution blocks.
- Replaces the flat OR-ing of ack/data_out/data_out_valid with a registered transaction engine.
- Adds per-transaction timeout, multiple-responder detection, a latched error code and a transaction counter.

Parameters:
- NUM_SLAVES, 5, number of slave ports (1..16)
- ADDR_W, 4, register address width
- DATA_W, 4, register data width
- TIMEOUT, 15, cycles in WAIT without any s_ack before abort (1..255)
- CNT_W, 8, width of transaction counter

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- m_valid  in  1  master request; level, held until m_ack or m_fault seen
- m_address  in  ADDR_W  request address
- m_data  in  DATA_W  request write data
- m_ack  out  1  one-cycle pulse: transaction completed by a slave
- m_fault  out  1  one-cycle pulse: timeout or multiple responders
- m_rdata  out  DATA_W  read-back data, held until next capture
- m_rdata_valid  out  1  one-cycle pulse, coincident with m_ack when a slave returned data
- s_valid  out  1  request broadcast to all slaves
- s_address  out  ADDR_W  latched request address
- s_data  out  DATA_W  latched request data
- s_ack  in  NUM_SLAVES  per-slave ack
- s_data_out  in  NUM_SLAVES*DATA_W  per-slave read data, slave i at bits [i*DATA_W +: DATA_W]
- s_data_out_valid  in  NUM_SLAVES  per-slave read-data qualifier
- busy  out  1  high in any state except IDLE
- err_code  out  2  sticky last error: 00 none, 01 timeout, 10 multiple ack, 11 both seen since last clear
- txn_count  out  CNT_W  count of completed (m_ack) transactions, wraps

Behaviour:
- All outputs registered. Reset (synchronous, any state) forces IDLE. All outputs go to 0, counters clear, on the next edge; an in-flight transaction is dropped silently.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On m_valid=1: latch m_address/m_data into s_address/s_data, set s_valid=1, clear the timeout counter, go to WAIT.
  - The first cycle of s_valid is the cycle after m_valid is sampled.
- WAIT:
  - Count cycles with s_ack==0. Sample s_ack each cycle.
  - Exactly one bit set (slave i):
    - Next cycle m_ack=1.
    - If s_data_out_valid[i]: m_rdata<=s_data_out slice i and m_rdata_valid=1.
    - txn_count+1; s_valid<=0; go to DONE.
  - Two or more bits set:
    - m_ack=1 and m_fault=1.
    - m_rdata <= bitwise OR of the slices whose data_out_valid is set; m_rdata_valid=1 if any is set.
    - err_code[1]<=1; txn_count+1; s_valid<=0; go to DONE.
  - Counter reaches TIMEOUT with no ack:
    - m_fault=1, m_ack=0, err_code[0]<=1; s_valid<=0; go to DONE.
    - Timeout fires on the TIMEOUT-th consecutive ack-free WAIT cycle.
  - An ack on the same cycle the counter hits TIMEOUT wins; no timeout is flagged.
- DONE:
  - Stay until m_valid==0, then go to IDLE.
  - Prevents a held-high m_valid from re-issuing. s_ack in DONE is ignored.
- err_code:
  - Sticky. Cleared only by reset or by the next successful single-ack transaction, which clears it to 00 in the same cycle m_ack pulses.
  - err_code=11 is reached by a timeout followed by a multiple-ack with no clean transaction in between (or the reverse).
- txn_count wraps from 2^CNT_W-1 to 0.
- Latency: m_valid sampled at cycle 0 → s_valid at 1. Single ack sampled at k → m_ack at k+1. Minimum 2 cycles request-to-ack.
- m_address/m_data changes during WAIT/DONE are ignored; s_address/s_data stay stable while s_valid=1.

Test Plan:
- Single write, NUM_SLAVES=5: m_valid=1, addr=4'h3, data=4'hA; slave 2 acks 3 cycles after s_valid → s_address=3, s_data=A; m_ack pulse 1 cycle; m_rdata_valid=0; txn_count=1; busy falls after m_valid drops.
- Readback: slave 4 acks with data_out_valid[4]=1, data 4'h6 → m_ack and m_rdata_valid together; m_rdata=6 and held afterwards.
- Timeout, TIMEOUT=15, no ack → m_fault on the 15th WAIT cycle; m_ack=0; err_code=01; txn_count unchanged; s_valid drops.
- Collision: slaves 0 and 1 ack the same cycle with data 4'h1 and 4'h4, both valid → m_ack=1, m_fault=1, m_rdata=5, err_code=10 (11 if the previous test's 01 was not cleared); next clean transaction → err_code=00.
- Held m_valid: keep m_valid=1 through a completion → exactly one s_valid burst and one m_ack; no second request until m_valid deasserts and reasserts.
- Reset mid-WAIT: assert rst while s_valid=1 → next cycle all outputs 0, state IDLE; a late s_ack produces no m_ack.
